// File: rtl/counter_pkg.sv
// Shared constants and types for the ripple counter slice.
package counter_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 4;

    typedef logic [CNT_WIDTH_DEFAULT-1:0] count_t;

endpackage : counter_pkg

// File: rtl/ripple_carry_counter_if.sv
// Count bus between the ripple counter and its consumers.
// Consumers sample q on the rising clk edge, after the ripple has settled.
interface ripple_carry_counter_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] q;

    modport master (output q);
    modport slave  (input  q);

endinterface : ripple_carry_counter_if

// File: rtl/ripple_carry_counter_t_ff.sv
// Falling-edge toggle flop with asynchronous active-low clear.
// One of these flops forms each counter stage.
module t_ff (
    output logic q,
    input  logic clk,
    input  logic reset
);

    logic toggle_d;
    logic toggle_q;

    // Next state is always the complement of the current state.
    always_comb begin
        toggle_d = ~toggle_q;
    end

    // The clear has priority, so a stage held in reset ignores its clock input.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign q = toggle_q;

endmodule : t_ff

// File: rtl/ripple_carry_counter.sv
// Asynchronous binary up-counter built from a chain of toggle flops.
// Stage 0 runs on the falling clk edge. Each later stage runs on the falling
// edge of the stage before it, so q passes through transient codes while the
// carry ripples. All stages share the asynchronous clear.
module ripple_carry_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             reset
);

    // Stage chain: a 1->0 transition on q[i-1] carries into stage i.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
        if (i == 0) begin : g_first
            t_ff u_t_ff (
                .q     (q[i]),
                .clk   (clk),
                .reset (reset)
            );
        end else begin : g_next
            t_ff u_t_ff (
                .q     (q[i]),
                .clk   (q[i-1]),
                .reset (reset)
            );
        end
    end

endmodule : ripple_carry_counter

// File: tb/tb_ripple_carry_counter.sv
// Directed bench for ripple_carry_counter (WIDTH = 4).
// Outputs are checked 1 time unit after clock edges. Reset is only changed
// between clock edges.
module tb_ripple_carry_counter;
    import counter_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ripple_carry_counter_if #(.WIDTH(CNT_WIDTH_DEFAULT)) cnt_if ();

    ripple_carry_counter #(.WIDTH(CNT_WIDTH_DEFAULT)) dut (
        .q     (cnt_if.q),
        .clk   (clk),
        .reset (reset)
    );

    // Period 10, starting low: falling edges occur at 10, 20, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stop a runaway simulation.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 20000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input count_t obs, input count_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Wait for a falling edge, then check the value that edge produced.
    task automatic edge_check(input string tag, input count_t exp);
        @(negedge clk);
        #1;
        check(tag, cnt_if.q, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;

        // Power-up: the counter is held at zero, including across a clk edge.
        #1;
        check("powerup", cnt_if.q, 4'b0000);
        edge_check("powerup_edge", 4'b0000);
        #1;
        reset = 1'b1;   // released at t=12, between edges

        // Count 20 edges. The value wraps after 1111 and ends at 0100.
        // Rising edges must not change q.
        for (int i = 1; i <= 20; i++) begin
            edge_check($sformatf("count_%0d", i), count_t'(i));
            @(posedge clk);
            #1;
            check($sformatf("rise_hold_%0d", i), cnt_if.q, count_t'(i));
        end

        // Mid-count reset at 0101 clears q before any edge.
        edge_check("count_21", 4'b0101);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_immediate", cnt_if.q, 4'b0000);
        edge_check("mid_reset_edge", 4'b0000);
        #2;
        reset = 1'b1;
        edge_check("after_mid_reset", 4'b0001);

        // Reset held across three falling edges.
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_check($sformatf("reset_held_%0d", i), 4'b0000);
        end
        #2;
        reset = 1'b1;

        // Carry through three stages: 0111 -> 1000.
        for (int i = 1; i <= 7; i++) begin
            edge_check($sformatf("recount_%0d", i), count_t'(i));
        end
        edge_check("carry_0111_1000", 4'b1000);
        for (int i = 9; i <= 15; i++) begin
            edge_check($sformatf("recount_%0d", i), count_t'(i));
        end

        // Wrap 1111 -> 0000 with no spurious extra count.
        edge_check("wrap_1111_0000", 4'b0000);
        @(posedge clk);
        #1;
        check("wrap_rise_hold", cnt_if.q, 4'b0000);
        edge_check("after_wrap", 4'b0001);

        // Clearing from 1111 must not toggle the downstream stages.
        for (int i = 2; i <= 15; i++) begin
            edge_check($sformatf("fill_%0d", i), count_t'(i));
        end
        #2;
        reset = 1'b0;
        #1;
        check("reset_from_ones", cnt_if.q, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check("release_no_count", cnt_if.q, 4'b0000);
        edge_check("after_ones_reset", 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ripple_carry_counter
